// File: rtl/state_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : state_sequencer_pkg
// Description : Shared state encoding, opcode constants and the mul/div
//               instruction decode used by the state sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package state_sequencer_pkg;

    // Sequencer states; codes 5-15 are illegal and fall back to HALT
    typedef enum logic [3:0] {
        HALT   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        EXEC1  = 4'd3,
        EXEC2  = 4'd4
    } state_t;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_J     = 6'b000010;

    // fun[5:2] shared by MULT/MULTU/DIV/DIVU
    localparam logic [3:0] FUN_MULDIV = 4'b0110;

    // True for R-type multiply/divide instructions
    function automatic logic is_muldiv(input logic [5:0] opcode, input logic [5:0] fun);
        return (opcode == OP_RTYPE) && (fun[5:2] == FUN_MULDIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wrap_counter.sv
`default_nettype none
// ============================================================================
// Module      : wrap_counter
// Description : Free-running enabled up-counter that wraps to zero at its
//               maximum value, with asynchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module wrap_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    // Count enabled cycles; natural overflow gives the wrap to zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/state_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : state_sequencer
// Description : Multi-cycle instruction sequencer (FETCH/DECODE/EXEC1/EXEC2)
//               with bus and mul/div stall handling, sticky HALT on a fetch
//               from address zero, and active-cycle / retired-instruction
//               counters.
// Revision    : 1.0 - initial release
// ============================================================================
module state_sequencer
    import state_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        waitrequest,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [5:0]  opcode,
    input  logic [5:0]  fun,
    input  logic [31:0] pc,
    input  logic        div_mult_busy,
    output logic [3:0]  state,
    output logic        active,
    output logic        stall,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
);

    state_t r_state;
    state_t w_next;
    logic   w_stall;
    logic   w_mem_wait;
    logic   w_muldiv_wait;
    logic   w_retire;

    // A bus transfer is pending and the slave has not accepted it
    assign w_mem_wait    = (memread | memwrite) & waitrequest;
    assign w_muldiv_wait = is_muldiv(opcode, fun) & div_mult_busy;

    // State register; reset abandons any in-flight instruction and refetches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and stall decode; both EXEC1 hold causes merge into one stall
    always_comb begin
        w_next  = HALT;
        w_stall = 1'b0;
        case (r_state)
            HALT: begin
                w_next = HALT;
            end
            FETCH: begin
                if (pc == 32'd0) begin
                    w_next = HALT;
                end else if (memread & waitrequest) begin
                    w_next  = FETCH;
                    w_stall = 1'b1;
                end else begin
                    w_next = DECODE;
                end
            end
            DECODE: begin
                w_next = EXEC1;
            end
            EXEC1: begin
                if (w_mem_wait | w_muldiv_wait) begin
                    w_next  = EXEC1;
                    w_stall = 1'b1;
                end else begin
                    w_next = EXEC2;
                end
            end
            EXEC2: begin
                if (w_mem_wait) begin
                    w_next  = EXEC2;
                    w_stall = 1'b1;
                end else begin
                    w_next = FETCH;
                end
            end
            default: begin
                w_next = HALT;
            end
        endcase
    end

    // An instruction retires only when EXEC2 completes back into FETCH
    assign w_retire = (r_state == EXEC2) && (w_next == FETCH);

    assign state  = r_state;
    assign active = (r_state != HALT);
    assign stall  = w_stall;

    wrap_counter #(
        .WIDTH (32)
    ) u_cycle_counter (
        .clk   (clk),
        .rst   (reset),
        .en    (active),
        .count (cycle_count)
    );

    wrap_counter #(
        .WIDTH (32)
    ) u_instr_counter (
        .clk   (clk),
        .rst   (reset),
        .en    (w_retire),
        .count (instr_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_state_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_state_sequencer
// Description : Directed self-checking bench for state_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_state_sequencer;
    import state_sequencer_pkg::*;

    logic        clk;
    logic        reset;
    logic        waitrequest;
    logic        memread;
    logic        memwrite;
    logic [5:0]  opcode;
    logic [5:0]  fun;
    logic [31:0] pc;
    logic        div_mult_busy;
    logic [3:0]  state;
    logic        active;
    logic        stall;
    logic [31:0] cycle_count;
    logic [31:0] instr_count;

    typedef struct {
        logic [3:0]  st;
        logic        act;
        logic [31:0] cyc;
        logic [31:0] ins;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec;
    int          n_err;
    logic [3:0]  mdl_state;
    logic [31:0] mdl_cyc;
    logic [31:0] mdl_ins;

    state_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .waitrequest   (waitrequest),
        .memread       (memread),
        .memwrite      (memwrite),
        .opcode        (opcode),
        .fun           (fun),
        .pc            (pc),
        .div_mult_busy (div_mult_busy),
        .state         (state),
        .active        (active),
        .stall         (stall),
        .cycle_count   (cycle_count),
        .instr_count   (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, check stall, push expected post-edge result,
    // then pop and compare after the edge.
    task automatic cyc(input logic rd, input logic wr, input logic wt, input logic busy,
                       input logic [31:0] pcv, input logic [5:0] op, input logic [5:0] fn,
                       input logic [3:0] exp_next, input logic exp_stall, input string tag);
        exp_t e;
        exp_t g;
        memread       = rd;
        memwrite      = wr;
        waitrequest   = wt;
        div_mult_busy = busy;
        pc            = pcv;
        opcode        = op;
        fun           = fn;
        #1;
        chk({tag, ".stall"}, {31'd0, stall}, {31'd0, exp_stall});
        if (mdl_state != 4'd0) mdl_cyc = mdl_cyc + 32'd1;
        if (mdl_state == 4'd4 && exp_next == 4'd1) mdl_ins = mdl_ins + 32'd1;
        mdl_state = exp_next;
        e.st  = exp_next;
        e.act = (exp_next != 4'd0);
        e.cyc = mdl_cyc;
        e.ins = mdl_ins;
        e.tag = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        g = sb_q.pop_front();
        chk({g.tag, ".state"},  {28'd0, state},  {28'd0, g.st});
        chk({g.tag, ".active"}, {31'd0, active}, {31'd0, g.act});
        chk({g.tag, ".cycles"}, cycle_count, g.cyc);
        chk({g.tag, ".instrs"}, instr_count, g.ins);
    endtask

    task automatic mdl_reset();
        mdl_state = 4'd1;
        mdl_cyc   = 32'd0;
        mdl_ins   = 32'd0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        mdl_reset();
        reset = 1'b1;
        waitrequest = 1'b0; memread = 1'b0; memwrite = 1'b0;
        opcode = 6'd0; fun = 6'd0; pc = 32'hBFC0_0000; div_mult_busy = 1'b0;
        #1;
        chk("rst.state",  {28'd0, state}, 32'd1);
        chk("rst.active", {31'd0, active}, 32'd1);
        chk("rst.cycles", cycle_count, 32'd0);
        chk("rst.instrs", instr_count, 32'd0);
        #1 reset = 1'b0;

        // ADDIU, no wait states
        cyc(1, 0, 0, 0, 32'hBFC0_0000, 6'b001001, 6'd0, 4'd2, 0, "addiu.f");
        cyc(0, 0, 0, 0, 32'hBFC0_0000, 6'b001001, 6'd0, 4'd3, 0, "addiu.d");
        cyc(0, 0, 0, 0, 32'hBFC0_0000, 6'b001001, 6'd0, 4'd4, 0, "addiu.e1");
        cyc(0, 0, 0, 0, 32'hBFC0_0000, 6'b001001, 6'd0, 4'd1, 0, "addiu.e2");
        chk("addiu.cyc_total", cycle_count, 32'd4);
        chk("addiu.ins_total", instr_count, 32'd1);

        // LW with a three-cycle wait in EXEC1
        cyc(1, 0, 0, 0, 32'hBFC0_0004, OP_LW, 6'd0, 4'd2, 0, "lw.f");
        cyc(0, 0, 0, 0, 32'hBFC0_0004, OP_LW, 6'd0, 4'd3, 0, "lw.d");
        for (int i = 0; i < 3; i++)
            cyc(1, 0, 1, 0, 32'hBFC0_0004, OP_LW, 6'd0, 4'd3, 1, "lw.e1wait");
        cyc(1, 0, 0, 0, 32'hBFC0_0004, OP_LW, 6'd0, 4'd4, 0, "lw.e1");
        cyc(0, 0, 0, 0, 32'hBFC0_0004, OP_LW, 6'd0, 4'd1, 0, "lw.e2");
        chk("lw.cyc_total", cycle_count, 32'd11);

        // MULT: busy holds EXEC1, overlapping bus waits do not add cycles
        cyc(1, 0, 0, 0, 32'hBFC0_0008, OP_RTYPE, 6'b011000, 4'd2, 0, "mult.f");
        cyc(0, 0, 0, 0, 32'hBFC0_0008, OP_RTYPE, 6'b011000, 4'd3, 0, "mult.d");
        for (int i = 0; i < 31; i++)
            cyc((i >= 10 && i < 20), 0, i[0], 1, 32'hBFC0_0008, OP_RTYPE, 6'b011000,
                4'd3, 1, "mult.busy");
        cyc(0, 0, 0, 0, 32'hBFC0_0008, OP_RTYPE, 6'b011000, 4'd4, 0, "mult.e1");
        cyc(0, 0, 0, 0, 32'hBFC0_0008, OP_RTYPE, 6'b011000, 4'd1, 0, "mult.e2");
        chk("mult.cyc_total", cycle_count, 32'd46);

        // Fetch stall, plus mem wait that does not apply to a non-muldiv busy
        cyc(1, 0, 1, 0, 32'hBFC0_000C, OP_SW, 6'd0, 4'd1, 1, "sw.fwait");
        cyc(1, 0, 0, 0, 32'hBFC0_000C, OP_SW, 6'd0, 4'd2, 0, "sw.f");
        cyc(0, 0, 0, 1, 32'hBFC0_000C, OP_SW, 6'd0, 4'd3, 0, "sw.d");
        cyc(0, 1, 0, 1, 32'hBFC0_000C, OP_SW, 6'd0, 4'd4, 0, "sw.e1");
        cyc(0, 1, 1, 0, 32'hBFC0_000C, OP_SW, 6'd0, 4'd4, 1, "sw.e2wait");

        // Counter wrap: preload both counters, then retire
        force dut.u_cycle_counter.r_count = 32'hFFFF_FFFF;
        force dut.u_instr_counter.r_count = 32'hFFFF_FFFF;
        #1;
        release dut.u_cycle_counter.r_count;
        release dut.u_instr_counter.r_count;
        mdl_cyc = 32'hFFFF_FFFF;
        mdl_ins = 32'hFFFF_FFFF;
        cyc(0, 1, 0, 0, 32'hBFC0_000C, OP_SW, 6'd0, 4'd1, 0, "wrap.e2");
        chk("wrap.cycles0", cycle_count, 32'd0);
        chk("wrap.instrs0", instr_count, 32'd0);

        // Reset while held in EXEC2
        cyc(1, 0, 0, 0, 32'hBFC0_0010, OP_SW, 6'd0, 4'd2, 0, "rsx.f");
        cyc(0, 0, 0, 0, 32'hBFC0_0010, OP_SW, 6'd0, 4'd3, 0, "rsx.d");
        cyc(0, 1, 0, 0, 32'hBFC0_0010, OP_SW, 6'd0, 4'd4, 0, "rsx.e1");
        cyc(0, 1, 1, 0, 32'hBFC0_0010, OP_SW, 6'd0, 4'd4, 1, "rsx.e2wait");
        reset = 1'b1;
        #1;
        chk("rsx.state",  {28'd0, state}, 32'd1);
        chk("rsx.active", {31'd0, active}, 32'd1);
        chk("rsx.cycles", cycle_count, 32'd0);
        chk("rsx.instrs", instr_count, 32'd0);
        #1 reset = 1'b0;
        mdl_reset();

        // Illegal state code falls to HALT on the next edge
        force dut.r_state = state_t'(4'd9);
        #1;
        release dut.r_state;
        mdl_state = 4'd9;
        cyc(0, 0, 0, 0, 32'hBFC0_0000, OP_J, 6'd0, 4'd0, 0, "illegal");
        reset = 1'b1;
        #1 reset = 1'b0;
        mdl_reset();

        // JR to 0, then fetch from pc 0 halts permanently
        cyc(1, 0, 0, 0, 32'hBFC0_0020, OP_RTYPE, 6'b001000, 4'd2, 0, "jr.f");
        cyc(0, 0, 0, 0, 32'hBFC0_0020, OP_RTYPE, 6'b001000, 4'd3, 0, "jr.d");
        cyc(0, 0, 0, 0, 32'hBFC0_0020, OP_RTYPE, 6'b001000, 4'd4, 0, "jr.e1");
        cyc(0, 0, 0, 0, 32'hBFC0_0020, OP_RTYPE, 6'b001000, 4'd1, 0, "jr.e2");
        cyc(1, 0, 1, 0, 32'h0000_0000, OP_RTYPE, 6'd0, 4'd0, 0, "halt.f");
        for (int i = 0; i < 4; i++)
            cyc(1, i[1], i[0], 1, 32'h0000_0000, OP_RTYPE, 6'b011000, 4'd0, 0, "halt.hold");
        chk("halt.cycles", cycle_count, 32'd5);
        chk("halt.instrs", instr_count, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
